if_fetch: RTL and testbench

Instruction-fetch stage that drives the IF/ID pipeline register. It holds the fetch PC and runs a request/acknowledge handshake with instruction memory. It presents `instr_F`, `PC_F`, `PC4_F` and `PC8_F` to IF/ID, inserting NOP bubbles while a fetch is outstanding. It obeys the hazard unit's `stall` and applies branch/jump redirects from D after the delay slot.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_fetch_if.sv | 31 +++
 rtl/if_fetch_pc_next_sel.sv | 31 +++
 rtl/if_fetch.sv | 130 +++++++++++++
 tb/tb_if_fetch.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the instruction-fetch slice.
//   XLEN          - datapath / address width
//   RESET_PC      - fetch address after reset
//   NOP           - instruction word presented on a pipeline bubble
//   fetch_state_t - fetch FSM state (WAIT for memory, HAVE an instruction)
package mips_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned WORD_B   = 4;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_HAVE = 1'b1
    } fetch_state_t;

endpackage : mips_pkg

// File: rtl/if_fetch_if.sv
// if_fetch_if: request/acknowledge bus between the fetch stage and
// instruction memory.
//   imem_req   - fetch request (fetch -> memory)
//   imem_addr  - word address being fetched, stable while imem_req is high
//   imem_ack   - response valid this cycle (memory -> fetch)
//   imem_rdata - instruction word, valid with imem_ack
interface if_fetch_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    // Fetch stage side.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Instruction memory side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface : if_fetch_if

// File: rtl/if_fetch_pc_next_sel.sv
// pc_next_sel: priority select of the next fetch PC when the F slot is
// consumed. A pending delay-slot redirect beats a live redirect, which
// beats sequential fetch.
//   pend_v      - a redirect was captured while the delay slot was in flight
//   pend_pc     - its target
//   redirect    - live D-stage redirect
//   redirect_pc - live redirect target
//   pc_seq      - sequential successor of the current PC
//   pc_next_c   - selected next PC (combinational)
module pc_next_sel
    import mips_pkg::*;
(
    input  logic            pend_v,
    input  logic [XLEN-1:0] pend_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] pc_seq,
    output logic [XLEN-1:0] pc_next_c
);

    // Priority mux: pend > redirect > sequential.
    always_comb begin
        pc_next_c = pc_seq;
        if (pend_v) begin
            pc_next_c = pend_pc;
        end else if (redirect) begin
            pc_next_c = redirect_pc;
        end
    end

endmodule : pc_next_sel

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding the IF/ID register.
// Holds the fetch PC, runs a req/ack handshake with instruction memory and
// presents one instruction per fetch, with NOP bubbles while a fetch is
// outstanding. Obeys stall and applies D-stage redirects after the delay slot.
//   clk, reset      - clock; synchronous active-high reset
//   stall           - hazard unit hold; the F slot is not consumed this edge
//   redirect        - D-stage branch taken / jump
//   redirect_pc     - redirect target, valid with redirect
//   imem            - instruction memory bus (master side)
//   instr_F         - instruction to IF/ID (NOP on a bubble)
//   PC_F            - address of instr_F
//   PC4_F, PC8_F    - PC_F+4 and PC_F+8, wrapping
//   valid_F         - 1 = real instruction, 0 = bubble
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP      = mips_pkg::NOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    if_fetch_if.master        imem,
    output logic [XLEN-1:0]   instr_F,
    output logic [XLEN-1:0]   PC_F,
    output logic [XLEN-1:0]   PC4_F,
    output logic [XLEN-1:0]   PC8_F,
    output logic              valid_F
);

    fetch_state_t    state_q,   state_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] ibuf_q,    ibuf_d;
    logic            pend_v_q,  pend_v_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic [XLEN-1:0] pc_seq_c;
    logic [XLEN-1:0] pc_next_c;

    assign pc_seq_c = pc_q + XLEN'(WORD_B);

    // Next fetch PC applied when the F slot is consumed.
    pc_next_sel u_pc_next_sel (
        .pend_v      (pend_v_q),
        .pend_pc     (pend_pc_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_seq      (pc_seq_c),
        .pc_next_c   (pc_next_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_WAIT;
            pc_q      <= RESET_PC;
            ibuf_q    <= NOP;
            pend_v_q  <= 1'b0;
            pend_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ibuf_q    <= ibuf_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ibuf_d    = ibuf_q;
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;

        unique case (state_q)
            ST_WAIT: begin
                // Redirect arriving before the delay slot is fetched: park the
                // target and let the delay slot at pc complete first. A stalled
                // branch re-asserts later, so it is ignored here.
                if (redirect && !stall && !pend_v_q) begin
                    pend_v_d  = 1'b1;
                    pend_pc_d = redirect_pc;
                end
                // Capture the response regardless of stall; the slot is
                // only held once an instruction is present.
                if (imem.imem_ack) begin
                    ibuf_d  = imem.imem_rdata;
                    state_d = ST_HAVE;
                end
            end
            ST_HAVE: begin
                if (!stall) begin
                    state_d  = ST_WAIT;
                    pc_d     = pc_next_c;
                    pend_v_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Output decode; reset forces a clean bubble at the reset PC.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        instr_F        = NOP;
        valid_F        = 1'b0;
        PC_F           = pc_q;

        if (reset) begin
            imem.imem_addr = RESET_PC;
            PC_F           = RESET_PC;
        end else if (state_q == ST_HAVE) begin
            instr_F = ibuf_q;
            valid_F = 1'b1;
        end else begin
            imem.imem_req = 1'b1;
        end

        PC4_F = PC_F + XLEN'(WORD_B);
        PC8_F = PC_F + XLEN'(2 * WORD_B);
    end

endmodule : if_fetch

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vector table for the fetch stage's documented
// scenarios, followed by randomized stall/redirect/latency traffic checked
// against a delivery-level reference model and a memory-content property.
module tb_if_fetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_F, PC_F, PC4_F, PC8_F;
    logic        valid_F;

    if_fetch_if imem ();

    if_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .instr_F     (instr_F),
        .PC_F        (PC_F),
        .PC4_F       (PC4_F),
        .PC8_F       (PC8_F),
        .valid_F     (valid_F)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [NV];

    localparam logic [31:0] I0 = 32'h2008_0001;
    localparam logic [31:0] A1 = 32'h1111_0001;
    localparam logic [31:0] A2 = 32'h2222_0002;
    localparam logic [31:0] A3 = 32'h3333_0003;
    localparam logic [31:0] A4 = 32'h4444_0004;
    localparam logic [31:0] A5 = 32'h5555_0005;
    localparam logic [31:0] A6 = 32'h6666_0006;
    localparam logic [31:0] A7 = 32'h7777_0007;
    localparam logic [31:0] A8 = 32'h8888_0008;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    function automatic vec_t mk(logic rst, logic st, logic rd, logic [31:0] rpc,
                                logic ack, logic [31:0] rdata,
                                logic e_req, logic [31:0] e_addr, logic e_valid,
                                logic [31:0] e_instr, logic [31:0] e_pc);
        vec_t v;
        v.rst = rst;   v.st = st;         v.rd = rd;           v.rpc = rpc;
        v.ack = ack;   v.rdata = rdata;   v.e_req = e_req;     v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    // Program memory used by the random phase: content is a function of address.
    function automatic logic [31:0] mem_word(logic [31:0] a);
        logic [31:0] x;
        x = a;
        return {x[15:0] ^ 16'h5A5A, x[31:16] ^ 16'h1234};
    endfunction

    task automatic drive(logic rst, logic st, logic rd, logic [31:0] rpc,
                         logic ack, logic [31:0] rdata);
        reset           = rst;
        stall           = st;
        redirect        = rd;
        redirect_pc     = rpc;
        imem.imem_ack   = ack;
        imem.imem_rdata = rdata;
    endtask

    task automatic check_out(string name, logic e_req, logic [31:0] e_addr,
                             logic e_valid, logic [31:0] e_instr, logic [31:0] e_pc);
        logic ok;
        logic [31:0] e_pc4, e_pc8;
        e_pc4 = e_pc + 32'd4;
        e_pc8 = e_pc + 32'd8;
        ok = (imem.imem_req === e_req) && (!e_req || imem.imem_addr === e_addr) &&
             (valid_F === e_valid) && (instr_F === e_instr) && (PC_F === e_pc) &&
             (PC4_F === e_pc4) && (PC8_F === e_pc8);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h pc8=%h; want req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h pc8=%h",
                     name, imem.imem_req, imem.imem_addr, valid_F, instr_F, PC_F, PC4_F, PC8_F,
                     e_req, e_addr, e_valid, e_instr, e_pc, e_pc4, e_pc8);
        end
    endtask

    // Reference model state: the address being fetched, whether an
    // instruction is sitting in the F slot, and any parked delay-slot target.
    logic [31:0] m_pc, m_ibuf, m_pend_pc;
    logic        m_full, m_pend;

    logic        r_rst, r_st, r_rd, r_ack;
    logic [31:0] r_rpc, r_rdata;
    int          lat;
    int          delivered;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset, first fetch, stall hold, redirects, reset mid-fetch, zero-wait, wrap.
        vecs[0]  = mk(1,0,0,32'h0,0,32'h0,        0,32'h3000,0,NOP,32'h3000);
        vecs[1]  = mk(1,0,0,32'h0,0,32'h0,        0,32'h3000,0,NOP,32'h3000);
        vecs[2]  = mk(0,0,0,32'h0,0,32'h0,        1,32'h3000,0,NOP,32'h3000);
        vecs[3]  = mk(0,0,0,32'h0,1,I0,           1,32'h3000,0,NOP,32'h3000);
        vecs[4]  = mk(0,0,0,32'h0,0,32'h0,        0,32'h0,1,I0,32'h3000);
        vecs[5]  = mk(0,0,0,32'h0,1,A1,           1,32'h3004,0,NOP,32'h3004);
        vecs[6]  = mk(0,1,0,32'h0,1,BAD,          0,32'h0,1,A1,32'h3004);
        vecs[7]  = mk(0,1,0,32'h0,0,32'h0,        0,32'h0,1,A1,32'h3004);
        vecs[8]  = mk(0,1,0,32'h0,0,32'h0,        0,32'h0,1,A1,32'h3004);
        vecs[9]  = mk(0,0,0,32'h0,0,32'h0,        0,32'h0,1,A1,32'h3004);
        vecs[10] = mk(0,0,0,32'h0,0,32'h0,        1,32'h3008,0,NOP,32'h3008);
        vecs[11] = mk(0,0,1,32'h3200,0,32'h0,     1,32'h3008,0,NOP,32'h3008);
        vecs[12] = mk(0,0,0,32'h0,0,32'h0,        1,32'h3008,0,NOP,32'h3008);
        vecs[13] = mk(0,0,0,32'h0,1,A2,           1,32'h3008,0,NOP,32'h3008);
        vecs[14] = mk(0,0,1,32'h3300,0,32'h0,     0,32'h0,1,A2,32'h3008);
        vecs[15] = mk(0,0,0,32'h0,1,A3,           1,32'h3200,0,NOP,32'h3200);
        vecs[16] = mk(0,0,1,32'h3100,0,32'h0,     0,32'h0,1,A3,32'h3200);
        vecs[17] = mk(0,0,0,32'h0,0,32'h0,        1,32'h3100,0,NOP,32'h3100);
        vecs[18] = mk(0,1,1,32'h3400,0,32'h0,     1,32'h3100,0,NOP,32'h3100);
        vecs[19] = mk(0,1,0,32'h0,1,A4,           1,32'h3100,0,NOP,32'h3100);
        vecs[20] = mk(0,0,0,32'h0,0,32'h0,        0,32'h0,1,A4,32'h3100);
        vecs[21] = mk(0,0,1,32'h3500,0,32'h0,     1,32'h3104,0,NOP,32'h3104);
        vecs[22] = mk(1,0,0,32'h0,0,32'h0,        0,32'h0,0,NOP,32'h3000);
        vecs[23] = mk(0,0,0,32'h0,0,32'h0,        1,32'h3000,0,NOP,32'h3000);
        vecs[24] = mk(0,0,0,32'h0,1,A5,           1,32'h3000,0,NOP,32'h3000);
        vecs[25] = mk(0,0,0,32'h0,0,32'h0,        0,32'h0,1,A5,32'h3000);
        vecs[26] = mk(0,0,0,32'h0,1,A6,           1,32'h3004,0,NOP,32'h3004);
        vecs[27] = mk(0,0,0,32'h0,0,32'h0,        0,32'h0,1,A6,32'h3004);
        vecs[28] = mk(0,0,0,32'h0,1,A7,           1,32'h3008,0,NOP,32'h3008);
        vecs[29] = mk(0,0,1,32'hFFFF_FFFC,0,32'h0,0,32'h0,1,A7,32'h3008);
        vecs[30] = mk(0,0,0,32'h0,1,A8,           1,32'hFFFF_FFFC,0,NOP,32'hFFFF_FFFC);
        vecs[31] = mk(0,0,0,32'h0,0,32'h0,        0,32'h0,1,A8,32'hFFFF_FFFC);
        vecs[32] = mk(0,0,0,32'h0,0,32'h0,        1,32'h0000_0000,0,NOP,32'h0000_0000);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                      vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
        end

        // Random traffic; the first two cycles reset DUT and model together.
        m_pc = RESET_PC; m_ibuf = NOP; m_pend_pc = RESET_PC; m_full = 1'b0; m_pend = 1'b0;
        lat = 0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            r_rst = (cyc < 2) || ($urandom_range(0, 199) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_rd  = ($urandom_range(0, 5) == 0);
            r_rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2))
                                                : ($urandom & 32'hFFFF_FFFC);
            r_ack = 1'b0;
            if (!r_rst && !m_full) begin
                if (lat == 0) r_ack = 1'b1;
                else          lat--;
            end
            r_rdata = r_ack ? mem_word(m_pc) : $urandom;
            drive(r_rst, r_st, r_rd, r_rpc, r_ack, r_rdata);
            #1;

            if (r_rst)
                check_out("rand_reset", 1'b0, RESET_PC, 1'b0, NOP, RESET_PC);
            else
                check_out("rand", !m_full, m_pc, m_full, m_full ? m_ibuf : NOP, m_pc);

            if (!r_rst && valid_F === 1'b1) begin
                checks++;
                if (instr_F !== mem_word(PC_F)) begin
                    failures++;
                    $display("FAIL rand_content: instr_F=%h at PC_F=%h, want %h",
                             instr_F, PC_F, mem_word(PC_F));
                end
                if (!r_st) delivered++;
            end

            @(posedge clk);
            if (r_rst) begin
                m_pc = RESET_PC; m_ibuf = NOP; m_full = 1'b0; m_pend = 1'b0;
            end else if (!m_full) begin
                if (r_rd && !r_st && !m_pend) begin
                    m_pend    = 1'b1;
                    m_pend_pc = r_rpc;
                end
                if (r_ack) begin
                    m_full = 1'b1;
                    m_ibuf = r_rdata;
                    lat    = $urandom_range(0, 3);
                end
            end else if (!r_st) begin
                m_full = 1'b0;
                if (m_pend)     m_pc = m_pend_pc;
                else if (r_rd)  m_pc = r_rpc;
                else            m_pc = m_pc + 32'd4;
                m_pend = 1'b0;
            end
        end

        // The random run must have made real forward progress.
        checks++;
        if (delivered < 300) begin
            failures++;
            $display("FAIL progress: delivered=%0d instructions, want at least 300", delivered);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_fetch
